// File: rtl/maccum_arbiter.sv
// -----------------------------------------------------------------------------
// maccum_arbiter
//
// Shares one backward multiply-accumulate datapath between two requesters
// (A and B). One transaction is in flight at a time:
//   IDLE  -> accept one request (round-robin priority, single requester always wins)
//   ISSUE -> send the registered weight matrix and delta vector to the datapath
//   WAIT  -> accept the accumulated result from the datapath
//   RESP  -> return the result to the requester that owns the transaction
//
// Handshake rule for every channel: a transfer happens on a rising edge of
// iCLK where both valid and ready are high. A valid, once raised by this block,
// stays high with stable data until its transfer.
//
// Ports
//   iCLK, iRST                         clock, synchronous active-high reset
//   iValid/oReady/iData_AM_*A, *B      request channels (weight + delta)
//   oValid/iReady/oData_BM_Weight      weight channel to the datapath
//   oValid/iReady/oData_BM_Delta       delta channel to the datapath
//   iValid/oReady/iData_AM_Accum       result channel from the datapath
//   oValid/iReady/oData_BM_RspA, RspB  result returned to A / B
//   oBusy                              high whenever the FSM is not IDLE
//   oDbg_State, oDbg_Prio, oDbg_Owner  debug view of FSM state, priority, owner
// -----------------------------------------------------------------------------
module maccum_arbiter #(
  parameter int NN = 7,
  parameter int NC = 11,
  parameter int WF = 5,
  localparam int WA = $clog2(NN) - 1 + WF,
  localparam int WW = NC * NN * WF,
  localparam int DW = NN * WF,
  localparam int AW = NC * WA
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iValid_AM_ReqA,
  output logic          oReady_AM_ReqA,
  input  logic [WW-1:0] iData_AM_WeightA,
  input  logic [DW-1:0] iData_AM_DeltaA,
  input  logic          iValid_AM_ReqB,
  output logic          oReady_AM_ReqB,
  input  logic [WW-1:0] iData_AM_WeightB,
  input  logic [DW-1:0] iData_AM_DeltaB,
  output logic          oValid_BM_Weight,
  input  logic          iReady_BM_Weight,
  output logic [WW-1:0] oData_BM_Weight,
  output logic          oValid_BM_Delta,
  input  logic          iReady_BM_Delta,
  output logic [DW-1:0] oData_BM_Delta,
  input  logic          iValid_AM_Accum,
  output logic          oReady_AM_Accum,
  input  logic [AW-1:0] iData_AM_Accum,
  output logic          oValid_BM_RspA,
  input  logic          iReady_BM_RspA,
  output logic [AW-1:0] oData_BM_RspA,
  output logic          oValid_BM_RspB,
  input  logic          iReady_BM_RspB,
  output logic [AW-1:0] oData_BM_RspB,
  output logic          oBusy,
  output logic [1:0]    oDbg_State,
  output logic          oDbg_Prio,
  output logic          oDbg_Owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Requester encoding used for both prio and owner.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic          owner_q, owner_d;
  logic          wiss_q, wiss_d;     // weight still to be issued
  logic          diss_q, diss_d;     // delta still to be issued
  logic [WW-1:0] weight_q, weight_d;
  logic [DW-1:0] delta_q, delta_d;
  logic [AW-1:0] accum_q, accum_d;

  logic ready_a, ready_b, ready_acc, rsp_a, rsp_b;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      prio_q   <= REQ_A;
      owner_q  <= REQ_A;
      wiss_q   <= 1'b0;
      diss_q   <= 1'b0;
      weight_q <= '0;
      delta_q  <= '0;
      accum_q  <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      wiss_q   <= wiss_d;
      diss_q   <= diss_d;
      weight_q <= weight_d;
      delta_q  <= delta_d;
      accum_q  <= accum_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    wiss_d    = wiss_q;
    diss_d    = diss_q;
    weight_d  = weight_q;
    delta_d   = delta_q;
    accum_d   = accum_q;
    ready_a   = 1'b0;
    ready_b   = 1'b0;
    ready_acc = 1'b0;
    rsp_a     = 1'b0;
    rsp_b     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Priority only matters when both requesters are valid, so at most
        // one ready is ever high.
        ready_a = iValid_AM_ReqA & ((prio_q == REQ_A) | ~iValid_AM_ReqB);
        ready_b = iValid_AM_ReqB & ((prio_q == REQ_B) | ~iValid_AM_ReqA);
        if (ready_a) begin
          weight_d = iData_AM_WeightA;
          delta_d  = iData_AM_DeltaA;
          owner_d  = REQ_A;
        end else if (ready_b) begin
          weight_d = iData_AM_WeightB;
          delta_d  = iData_AM_DeltaB;
          owner_d  = REQ_B;
        end
        if (ready_a | ready_b) begin
          wiss_d  = 1'b1;
          diss_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (wiss_q & iReady_BM_Weight) wiss_d = 1'b0;
        if (diss_q & iReady_BM_Delta)  diss_d = 1'b0;
        // Leave as soon as the last outstanding flag clears, so two
        // same-cycle transfers still cost only one ISSUE cycle.
        if (~wiss_d & ~diss_d) state_d = S_WAIT;
      end

      S_WAIT: begin
        ready_acc = 1'b1;
        if (iValid_AM_Accum) begin
          accum_d = iData_AM_Accum;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        rsp_a = (owner_q == REQ_A);
        rsp_b = (owner_q == REQ_B);
        if ((rsp_a & iReady_BM_RspA) | (rsp_b & iReady_BM_RspB)) begin
          state_d = S_IDLE;
          prio_d  = ~owner_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign oReady_AM_ReqA   = ready_a;
  assign oReady_AM_ReqB   = ready_b;
  assign oValid_BM_Weight = (state_q == S_ISSUE) & wiss_q;
  assign oValid_BM_Delta  = (state_q == S_ISSUE) & diss_q;
  assign oData_BM_Weight  = weight_q;
  assign oData_BM_Delta   = delta_q;
  assign oReady_AM_Accum  = ready_acc;
  assign oValid_BM_RspA   = rsp_a;
  assign oValid_BM_RspB   = rsp_b;
  assign oData_BM_RspA    = accum_q;
  assign oData_BM_RspB    = accum_q;
  assign oBusy            = (state_q != S_IDLE);
  assign oDbg_State       = state_q;
  assign oDbg_Prio        = prio_q;
  assign oDbg_Owner       = owner_q;

endmodule

// File: tb/tb_maccum_arbiter.sv
// -----------------------------------------------------------------------------
// tb_maccum_arbiter
//
// Directed scenarios for the arbiter (reset, single request, alternating
// grants, weight backpressure, response backpressure, mid-transaction reset)
// followed by a randomized run checked against a transaction-level model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 more
// time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_maccum_arbiter;

  localparam int NN = 7;
  localparam int NC = 11;
  localparam int WF = 5;
  localparam int WA = $clog2(NN) - 1 + WF;
  localparam int WW = NC * NN * WF;
  localparam int DW = NN * WF;
  localparam int AW = NC * WA;

  logic          iCLK, iRST;
  logic          iValid_AM_ReqA, oReady_AM_ReqA;
  logic [WW-1:0] iData_AM_WeightA;
  logic [DW-1:0] iData_AM_DeltaA;
  logic          iValid_AM_ReqB, oReady_AM_ReqB;
  logic [WW-1:0] iData_AM_WeightB;
  logic [DW-1:0] iData_AM_DeltaB;
  logic          oValid_BM_Weight, iReady_BM_Weight;
  logic [WW-1:0] oData_BM_Weight;
  logic          oValid_BM_Delta, iReady_BM_Delta;
  logic [DW-1:0] oData_BM_Delta;
  logic          iValid_AM_Accum, oReady_AM_Accum;
  logic [AW-1:0] iData_AM_Accum;
  logic          oValid_BM_RspA, iReady_BM_RspA;
  logic [AW-1:0] oData_BM_RspA;
  logic          oValid_BM_RspB, iReady_BM_RspB;
  logic [AW-1:0] oData_BM_RspB;
  logic          oBusy;
  logic [1:0]    oDbg_State;
  logic          oDbg_Prio, oDbg_Owner;

  int n_cmp = 0;
  int n_err = 0;

  maccum_arbiter #(.NN(NN), .NC(NC), .WF(WF)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iValid_AM_ReqA(iValid_AM_ReqA), .oReady_AM_ReqA(oReady_AM_ReqA),
    .iData_AM_WeightA(iData_AM_WeightA), .iData_AM_DeltaA(iData_AM_DeltaA),
    .iValid_AM_ReqB(iValid_AM_ReqB), .oReady_AM_ReqB(oReady_AM_ReqB),
    .iData_AM_WeightB(iData_AM_WeightB), .iData_AM_DeltaB(iData_AM_DeltaB),
    .oValid_BM_Weight(oValid_BM_Weight), .iReady_BM_Weight(iReady_BM_Weight),
    .oData_BM_Weight(oData_BM_Weight),
    .oValid_BM_Delta(oValid_BM_Delta), .iReady_BM_Delta(iReady_BM_Delta),
    .oData_BM_Delta(oData_BM_Delta),
    .iValid_AM_Accum(iValid_AM_Accum), .oReady_AM_Accum(oReady_AM_Accum),
    .iData_AM_Accum(iData_AM_Accum),
    .oValid_BM_RspA(oValid_BM_RspA), .iReady_BM_RspA(iReady_BM_RspA),
    .oData_BM_RspA(oData_BM_RspA),
    .oValid_BM_RspB(oValid_BM_RspB), .iReady_BM_RspB(iReady_BM_RspB),
    .oData_BM_RspB(oData_BM_RspB),
    .oBusy(oBusy), .oDbg_State(oDbg_State), .oDbg_Prio(oDbg_Prio),
    .oDbg_Owner(oDbg_Owner)
  );

  // ---------------------------------------------------------------- clock/reset
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    iRST             = 1'b1;
    iValid_AM_ReqA   = 1'b0;
    iValid_AM_ReqB   = 1'b0;
    iValid_AM_Accum  = 1'b0;
    iReady_BM_Weight = 1'b1;
    iReady_BM_Delta  = 1'b1;
    iReady_BM_RspA   = 1'b1;
    iReady_BM_RspB   = 1'b1;
    iData_AM_WeightA = '0;
    iData_AM_DeltaA  = '0;
    iData_AM_WeightB = '0;
    iData_AM_DeltaB  = '0;
    iData_AM_Accum   = '0;
    next_cycle();
    next_cycle();
    iRST = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus gen
  function automatic logic [WW-1:0] rnd_w();
    logic [WW-1:0] r;
    for (int i = 0; i < WW; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_d();
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [AW-1:0] rnd_a();
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({oValid_BM_Weight, oValid_BM_Delta, oValid_BM_RspA, oValid_BM_RspB, oReady_AM_Accum, oBusy} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 000000", {oValid_BM_Weight, oValid_BM_Delta, oValid_BM_RspA, oValid_BM_RspB, oReady_AM_Accum, oBusy});
    end
    n_cmp++;
    if ({oReady_AM_ReqA, oReady_AM_ReqB} !== 2'b00) begin
      n_err++; $display("FAIL reset_req_ready: got %b expected 00", {oReady_AM_ReqA, oReady_AM_ReqB});
    end
    n_cmp++;
    if ({oData_BM_Weight, oData_BM_Delta, oData_BM_RspA} !== '0) begin
      n_err++; $display("FAIL reset_data: data registers not cleared");
    end
  endtask

  task automatic test_single_a();
    logic [WW-1:0] wa;
    logic [DW-1:0] da;
    logic [AW-1:0] acc;
    bit            rspb_seen;
    wa = rnd_w(); da = rnd_d(); acc = rnd_a();
    rspb_seen = 1'b0;
    do_reset();
    // cycle 0: request
    iValid_AM_ReqA = 1'b1; iData_AM_WeightA = wa; iData_AM_DeltaA = da;
    #1;
    n_cmp++;
    if ({oReady_AM_ReqA, oReady_AM_ReqB} !== 2'b10) begin
      n_err++; $display("FAIL single_req_ready: got %b expected 10", {oReady_AM_ReqA, oReady_AM_ReqB});
    end
    rspb_seen |= oValid_BM_RspB;
    next_cycle();
    // cycle 1: issue; change the request inputs to prove data was registered
    iValid_AM_ReqA = 1'b0; iData_AM_WeightA = rnd_w(); iData_AM_DeltaA = rnd_d();
    #1;
    n_cmp++;
    if ({oValid_BM_Weight, oValid_BM_Delta, oBusy, oReady_AM_Accum} !== 4'b1110) begin
      n_err++; $display("FAIL single_issue_ctl: got %b expected 1110", {oValid_BM_Weight, oValid_BM_Delta, oBusy, oReady_AM_Accum});
    end
    n_cmp++;
    if (oData_BM_Weight !== wa) begin
      n_err++; $display("FAIL single_weight: got %h expected %h", oData_BM_Weight, wa);
    end
    n_cmp++;
    if (oData_BM_Delta !== da) begin
      n_err++; $display("FAIL single_delta: got %h expected %h", oData_BM_Delta, da);
    end
    rspb_seen |= oValid_BM_RspB;
    next_cycle();
    // cycle 2: accum returned
    iValid_AM_Accum = 1'b1; iData_AM_Accum = acc;
    #1;
    n_cmp++;
    if ({oReady_AM_Accum, oValid_BM_Weight, oValid_BM_Delta} !== 3'b100) begin
      n_err++; $display("FAIL single_wait: got %b expected 100", {oReady_AM_Accum, oValid_BM_Weight, oValid_BM_Delta});
    end
    rspb_seen |= oValid_BM_RspB;
    next_cycle();
    // cycle 3: response, 3 cycles after request accept
    iValid_AM_Accum = 1'b0; iData_AM_Accum = rnd_a();
    #1;
    n_cmp++;
    if (oValid_BM_RspA !== 1'b1 || oData_BM_RspA !== acc) begin
      n_err++; $display("FAIL single_rspA: got v=%b d=%h expected v=1 d=%h", oValid_BM_RspA, oData_BM_RspA, acc);
    end
    rspb_seen |= oValid_BM_RspB;
    next_cycle();
    // cycle 4: back to idle
    #1;
    n_cmp++;
    if ({oBusy, oValid_BM_RspA} !== 2'b00) begin
      n_err++; $display("FAIL single_done: got %b expected 00", {oBusy, oValid_BM_RspA});
    end
    rspb_seen |= oValid_BM_RspB;
    n_cmp++;
    if (rspb_seen !== 1'b0) begin
      n_err++; $display("FAIL single_rspB_never: got %b expected 0", rspb_seen);
    end
  endtask

  task automatic test_alternate();
    logic [WW-1:0] w[2];
    logic [AW-1:0] acc_exp;
    int            g_who[$];
    int            g_cyc[$];
    int            last;
    w[0] = rnd_w(); w[1] = rnd_w();
    acc_exp = '0;
    last = 0;
    do_reset();
    iValid_AM_ReqA = 1'b1; iData_AM_WeightA = w[0]; iData_AM_DeltaA = rnd_d();
    iValid_AM_ReqB = 1'b1; iData_AM_WeightB = w[1]; iData_AM_DeltaB = rnd_d();
    iValid_AM_Accum = 1'b1;
    for (int c = 0; c < 16; c++) begin
      iData_AM_Accum = rnd_a();
      #1;
      if (oReady_AM_ReqA) begin g_who.push_back(0); g_cyc.push_back(c); last = 0; end
      if (oReady_AM_ReqB) begin g_who.push_back(1); g_cyc.push_back(c); last = 1; end
      if (oValid_BM_Weight) begin
        n_cmp++;
        if (oData_BM_Weight !== w[last]) begin
          n_err++; $display("FAIL alt_weight c%0d: got %h expected %h", c, oData_BM_Weight, w[last]);
        end
      end
      if (oReady_AM_Accum) acc_exp = iData_AM_Accum;
      if (oValid_BM_RspA || oValid_BM_RspB) begin
        n_cmp++;
        if ({oValid_BM_RspA, oValid_BM_RspB} !== (last == 0 ? 2'b10 : 2'b01) ||
            (last == 0 ? oData_BM_RspA : oData_BM_RspB) !== acc_exp) begin
          n_err++; $display("FAIL alt_rsp c%0d: got v=%b dA=%h dB=%h expected owner=%0d d=%h", c, {oValid_BM_RspA, oValid_BM_RspB}, oData_BM_RspA, oData_BM_RspB, last, acc_exp);
        end
      end
      next_cycle();
    end
    n_cmp++;
    if (g_who.size() != 4) begin
      n_err++; $display("FAIL alt_grant_count: got %0d expected 4", g_who.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (g_who[i] != (i % 2) || g_cyc[i] != 4 * i) begin
          n_err++; $display("FAIL alt_grant%0d: got who=%0d cyc=%0d expected who=%0d cyc=%0d", i, g_who[i], g_cyc[i], i % 2, 4 * i);
        end
      end
    end
  endtask

  task automatic test_weight_stall();
    logic [WW-1:0] wa;
    int            d_xfers;
    wa = rnd_w();
    d_xfers = 0;
    do_reset();
    iValid_AM_ReqA = 1'b1; iData_AM_WeightA = wa; iData_AM_DeltaA = rnd_d();
    iReady_BM_Weight = 1'b0;
    next_cycle();
    iValid_AM_ReqA = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      iReady_BM_Weight = (c == 6);
      #1;
      if (oValid_BM_Delta && iReady_BM_Delta) d_xfers++;
      n_cmp++;
      if (oValid_BM_Weight !== 1'b1 || oData_BM_Weight !== wa || oValid_BM_Delta !== (c == 1) || oReady_AM_Accum !== 1'b0) begin
        n_err++; $display("FAIL stall_w c%0d: got vw=%b vd=%b racc=%b w=%h expected vw=1 vd=%b racc=0 w=%h", c, oValid_BM_Weight, oValid_BM_Delta, oReady_AM_Accum, oData_BM_Weight, (c == 1), wa);
      end
      next_cycle();
    end
    #1;
    n_cmp++;
    if ({oReady_AM_Accum, oValid_BM_Weight, oValid_BM_Delta} !== 3'b100) begin
      n_err++; $display("FAIL stall_w_wait: got %b expected 100", {oReady_AM_Accum, oValid_BM_Weight, oValid_BM_Delta});
    end
    n_cmp++;
    if (d_xfers != 1) begin
      n_err++; $display("FAIL stall_w_dxfers: got %0d expected 1", d_xfers);
    end
  endtask

  task automatic test_rsp_stall();
    logic [AW-1:0] acc;
    acc = rnd_a();
    do_reset();
    // B alone is granted even though prio is A after reset
    iValid_AM_ReqB = 1'b1; iData_AM_WeightB = rnd_w(); iData_AM_DeltaB = rnd_d();
    iReady_BM_RspB = 1'b0;
    #1;
    n_cmp++;
    if ({oReady_AM_ReqA, oReady_AM_ReqB} !== 2'b01) begin
      n_err++; $display("FAIL rstall_grantB: got %b expected 01", {oReady_AM_ReqA, oReady_AM_ReqB});
    end
    next_cycle();
    iValid_AM_ReqB = 1'b0; iValid_AM_ReqA = 1'b1;
    next_cycle();
    iValid_AM_Accum = 1'b1; iData_AM_Accum = acc;
    next_cycle();
    iValid_AM_Accum = 1'b0; iData_AM_Accum = rnd_a();
    for (int c = 3; c <= 13; c++) begin
      iReady_BM_RspB = (c == 13);
      #1;
      n_cmp++;
      if ({oValid_BM_RspB, oValid_BM_RspA, oReady_AM_ReqA, oReady_AM_ReqB, oBusy} !== 5'b10001 || oData_BM_RspB !== acc) begin
        n_err++; $display("FAIL rstall c%0d: got ctl=%b d=%h expected ctl=10001 d=%h", c, {oValid_BM_RspB, oValid_BM_RspA, oReady_AM_ReqA, oReady_AM_ReqB, oBusy}, oData_BM_RspB, acc);
      end
      next_cycle();
    end
    // after B's response prio is A, so A wins a contested request
    iValid_AM_ReqB = 1'b1;
    #1;
    n_cmp++;
    if ({oReady_AM_ReqA, oReady_AM_ReqB, oBusy, oValid_BM_RspB} !== 4'b1000) begin
      n_err++; $display("FAIL rstall_after: got %b expected 1000", {oReady_AM_ReqA, oReady_AM_ReqB, oBusy, oValid_BM_RspB});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // one full A transaction so that prio moves to B
    iValid_AM_ReqA = 1'b1; iData_AM_WeightA = rnd_w(); iData_AM_DeltaA = rnd_d();
    next_cycle();
    iValid_AM_ReqA = 1'b0;
    next_cycle();
    iValid_AM_Accum = 1'b1; iData_AM_Accum = rnd_a();
    next_cycle();
    iValid_AM_Accum = 1'b0;
    next_cycle();
    // second A transaction, single requester granted despite prio=B
    iValid_AM_ReqA = 1'b1;
    #1;
    n_cmp++;
    if ({oReady_AM_ReqA, oBusy} !== 2'b10) begin
      n_err++; $display("FAIL rmid_grantA: got %b expected 10", {oReady_AM_ReqA, oBusy});
    end
    next_cycle();
    iValid_AM_ReqA = 1'b0;
    next_cycle();
    #1;
    n_cmp++;
    if (oReady_AM_Accum !== 1'b1) begin
      n_err++; $display("FAIL rmid_in_wait: got %b expected 1", oReady_AM_Accum);
    end
    iRST = 1'b1;
    next_cycle();
    iRST = 1'b0;
    iValid_AM_Accum = 1'b1; iData_AM_Accum = rnd_a();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if ({oReady_AM_Accum, oValid_BM_RspA, oValid_BM_RspB, oBusy, oValid_BM_Weight} !== 5'b00000) begin
        n_err++; $display("FAIL rmid_after c%0d: got %b expected 00000", c, {oReady_AM_Accum, oValid_BM_RspA, oValid_BM_RspB, oBusy, oValid_BM_Weight});
      end
      next_cycle();
    end
    iValid_AM_ReqA = 1'b1; iValid_AM_ReqB = 1'b1;
    #1;
    n_cmp++;
    if ({oReady_AM_ReqA, oReady_AM_ReqB} !== 2'b10) begin
      n_err++; $display("FAIL rmid_prio: got %b expected 10", {oReady_AM_ReqA, oReady_AM_ReqB});
    end
  endtask

  // Randomized traffic against a transaction-level model: one job at a time,
  // it progresses through "weight delivered", "delta delivered", "result
  // received" and "result returned"; arbitration follows the round-robin rule.
  task automatic test_random();
    bit            m_busy, m_prio, m_owner, m_wdone, m_ddone, m_accd;
    logic [WW-1:0] m_w;
    logic [DW-1:0] m_d;
    logic [AW-1:0] m_acc;
    bit            pend_a, pend_b;
    bit            e_ra, e_rb, e_vw, e_vd, e_racc, e_rspa, e_rspb;
    int            done;
    m_busy = 0; m_prio = 0; m_owner = 0; m_wdone = 0; m_ddone = 0; m_accd = 0;
    m_w = '0; m_d = '0; m_acc = '0;
    pend_a = 0; pend_b = 0; done = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!pend_a && $urandom_range(0, 2) == 0) begin
        pend_a = 1; iData_AM_WeightA = rnd_w(); iData_AM_DeltaA = rnd_d();
      end
      if (!pend_b && $urandom_range(0, 2) == 0) begin
        pend_b = 1; iData_AM_WeightB = rnd_w(); iData_AM_DeltaB = rnd_d();
      end
      iValid_AM_ReqA   = pend_a;
      iValid_AM_ReqB   = pend_b;
      iReady_BM_Weight = ($urandom_range(0, 3) != 0);
      iReady_BM_Delta  = ($urandom_range(0, 3) != 0);
      iReady_BM_RspA   = ($urandom_range(0, 3) != 0);
      iReady_BM_RspB   = ($urandom_range(0, 3) != 0);
      iValid_AM_Accum  = ($urandom_range(0, 2) != 0);
      iData_AM_Accum   = rnd_a();
      #1;
      e_ra   = !m_busy && pend_a && (m_prio == 0 || !pend_b);
      e_rb   = !m_busy && pend_b && (m_prio == 1 || !pend_a);
      e_vw   = m_busy && !m_wdone;
      e_vd   = m_busy && !m_ddone;
      e_racc = m_busy && m_wdone && m_ddone && !m_accd;
      e_rspa = m_busy && m_accd && m_owner == 0;
      e_rspb = m_busy && m_accd && m_owner == 1;
      n_cmp++;
      if ({oReady_AM_ReqA, oReady_AM_ReqB, oValid_BM_Weight, oValid_BM_Delta, oReady_AM_Accum, oValid_BM_RspA, oValid_BM_RspB, oBusy}
          !== {e_ra, e_rb, e_vw, e_vd, e_racc, e_rspa, e_rspb, m_busy}) begin
        n_err++;
        $display("FAIL rnd_ctl c%0d: got %b expected %b", c,
                 {oReady_AM_ReqA, oReady_AM_ReqB, oValid_BM_Weight, oValid_BM_Delta, oReady_AM_Accum, oValid_BM_RspA, oValid_BM_RspB, oBusy},
                 {e_ra, e_rb, e_vw, e_vd, e_racc, e_rspa, e_rspb, m_busy});
      end
      if (e_vw) begin
        n_cmp++;
        if (oData_BM_Weight !== m_w) begin
          n_err++; $display("FAIL rnd_weight c%0d: got %h expected %h", c, oData_BM_Weight, m_w);
        end
      end
      if (e_vd) begin
        n_cmp++;
        if (oData_BM_Delta !== m_d) begin
          n_err++; $display("FAIL rnd_delta c%0d: got %h expected %h", c, oData_BM_Delta, m_d);
        end
      end
      if (e_rspa || e_rspb) begin
        n_cmp++;
        if ((e_rspa ? oData_BM_RspA : oData_BM_RspB) !== m_acc) begin
          n_err++; $display("FAIL rnd_rsp c%0d: got %h expected %h", c, (e_rspa ? oData_BM_RspA : oData_BM_RspB), m_acc);
        end
      end
      // advance the model by what transfers at the coming edge
      if (e_ra || e_rb) begin
        m_busy = 1; m_owner = e_rb; m_wdone = 0; m_ddone = 0; m_accd = 0;
        m_w = e_ra ? iData_AM_WeightA : iData_AM_WeightB;
        m_d = e_ra ? iData_AM_DeltaA : iData_AM_DeltaB;
        if (e_ra) pend_a = 0; else pend_b = 0;
      end
      if (e_vw && iReady_BM_Weight) m_wdone = 1;
      if (e_vd && iReady_BM_Delta)  m_ddone = 1;
      if (e_racc && iValid_AM_Accum) begin m_accd = 1; m_acc = iData_AM_Accum; end
      if ((e_rspa && iReady_BM_RspA) || (e_rspb && iReady_BM_RspB)) begin
        m_busy = 0; m_prio = ~m_owner; done++;
      end
      next_cycle();
    end
    n_cmp++;
    if (done < 20) begin
      n_err++; $display("FAIL rnd_progress: got %0d completed expected at least 20", done);
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    iRST = 1'b1;
    test_reset();
    test_single_a();
    test_alternate();
    test_weight_stall();
    test_rsp_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
